// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-code receive monitor.
// Helpers operate on a MAXW-wide vector; callers zero-extend and truncate.
package gray_mon_pkg;

    localparam int unsigned MAXW = 32;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        BACK = 2'b01,
        JUMP = 2'b10
    } err_code_e;

    function automatic logic [MAXW-1:0] g2b(input logic [MAXW-1:0] x);
        logic [MAXW-1:0] b;
        b[MAXW-1] = x[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ x[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [MAXW-1:0] x);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAXW; i++) begin
            n = n + 32'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus from a foreign clock domain.
module gray_sync #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_monitor.sv
// Receive-side monitor for a Gray-coded counter: converts to binary, flags
// legal +1 steps and wraps, and latches a sticky error on illegal transitions.
module gray_rx_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             enable,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             step,
    output logic             wrap,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [7:0]       wrap_cnt
);

    localparam int CNTW = $clog2(SYNC_STAGES + 1);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  fill_q, fill_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    err_code_e        code_q, code_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] bin_prev;
    int unsigned      diff_cnt;
    logic             changed;
    logic             is_step;
    logic             fill_done;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .gray_i (gray_in),
        .sync_o (s)
    );

    assign bin_s     = WIDTH'(g2b(MAXW'(s)));
    assign bin_prev  = WIDTH'(g2b(MAXW'(prev_q)));
    assign diff_cnt  = popcount(MAXW'(s ^ prev_q));
    assign changed   = (s != prev_q);
    assign is_step   = (diff_cnt == 32'd1) && (bin_s == bin_prev + WIDTH'(1));
    assign fill_done = (fill_q == CNTW'(SYNC_STAGES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            fill_q     <= '0;
            prev_q     <= '0;
            bin_q      <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= NONE;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            prev_q     <= prev_d;
            bin_q      <= bin_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            code_q     <= code_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            INIT: begin
                if (fill_done) state_d = TRACK;
                else           fill_d  = fill_q + CNTW'(1);
            end
            TRACK: begin
                if (enable && changed && !is_step) state_d = FAULT;
            end
            FAULT: begin
                if (clear_err) state_d = TRACK;
            end
            default: state_d = INIT;
        endcase
    end

    // prev/bin_out follow the synchronized sample in every post-INIT case,
    // including errors and disabled monitoring.
    always_comb begin
        prev_d     = prev_q;
        bin_d      = bin_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = err_q;
        code_d     = code_q;
        wrap_cnt_d = wrap_cnt_q;
        case (state_q)
            INIT: begin
                if (fill_done) begin
                    prev_d = s;
                    bin_d  = bin_s;
                end
            end
            TRACK: begin
                prev_d = s;
                bin_d  = bin_s;
                if (enable && changed) begin
                    if (is_step) begin
                        step_d = 1'b1;
                        if (bin_prev == '1) begin
                            wrap_d = 1'b1;
                            if (wrap_cnt_q != 8'hFF) wrap_cnt_d = wrap_cnt_q + 8'd1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        code_d = (diff_cnt == 32'd1) ? BACK : JUMP;
                    end
                end
            end
            FAULT: begin
                prev_d = s;
                bin_d  = bin_s;
                if (clear_err) begin
                    err_d  = 1'b0;
                    code_d = NONE;
                end
            end
            default: ;
        endcase
    end

    assign bin_out  = bin_q;
    assign step     = step_q;
    assign wrap     = wrap_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Directed self-checking bench for gray_rx_monitor (WIDTH=3, SYNC_STAGES=2).
module tb_gray_rx_monitor;
    import gray_mon_pkg::*;

    localparam int W  = 3;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] gray_in;
    logic         enable;
    logic         clear_err;
    logic [W-1:0] bin_out;
    logic         step;
    logic         wrap;
    logic         err;
    logic [1:0]   err_code;
    logic [7:0]   wrap_cnt;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    int wrap_pulses = 0;

    gray_rx_monitor #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .enable    (enable),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .step      (step),
        .wrap      (wrap),
        .err       (err),
        .err_code  (err_code),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_cnt <= step_cnt + 1;
        if (wrap === 1'b1) wrap_pulses <= wrap_pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [W-1:0] seq  [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [W-1:0] bexp [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    initial begin
        logic [W-1:0] cur;
        int exp_w;
        int exp_wp;
        int exp_steps;

        reset = 1'b1; enable = 1'b1; clear_err = 1'b0; gray_in = '0;
        tick(2);
        chk("rst_bin",   32'(bin_out), 32'd0);
        chk("rst_step",  32'(step), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_code",  32'(err_code), 32'd0);
        chk("rst_wcnt",  32'(wrap_cnt), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(INIT));

        reset = 1'b0;
        tick(2);
        chk("init_fill_state", 32'(dut.state_q), 32'(INIT));
        tick(1);
        chk("init_track_state", 32'(dut.state_q), 32'(TRACK));
        chk("init_bin", 32'(bin_out), 32'd0);
        tick(3);
        chk("idle_no_step", 32'(step_cnt), 32'd0);

        // Full legal cycle through all eight codes
        gray_in = seq[1];
        tick(3);
        chk("step_latency", 32'(step), 32'd1);
        chk("bin_1", 32'(bin_out), 32'(bexp[1]));
        tick(1);
        chk("step_single", 32'(step), 32'd0);
        for (int i = 2; i < 8; i++) begin
            gray_in = seq[i];
            tick(4);
            chk($sformatf("bin_seq%0d", i), 32'(bin_out), 32'(bexp[i]));
        end
        gray_in = seq[8];
        tick(3);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        chk("wrap_step",  32'(step), 32'd1);
        tick(1);
        chk("wrap_single", 32'(wrap), 32'd0);
        chk("bin_wrap0",   32'(bin_out), 32'(bexp[8]));
        chk("seq_steps",   32'(step_cnt), 32'd8);
        chk("seq_wraps",   32'(wrap_pulses), 32'd1);
        chk("seq_wcnt",    32'(wrap_cnt), 32'd1);
        chk("seq_err",     32'(err), 32'd0);

        // Backward step
        gray_in = 3'b001; tick(4);
        gray_in = 3'b011; tick(4);
        chk("pre_back_bin", 32'(bin_out), 32'd2);
        gray_in = 3'b001; tick(4);
        chk("back_err",   32'(err), 32'd1);
        chk("back_code",  32'(err_code), 32'd1);
        chk("back_bin",   32'(bin_out), 32'd1);
        chk("back_steps", 32'(step_cnt), 32'd10);
        gray_in = 3'b011; tick(4);
        chk("fault_bin",     32'(bin_out), 32'd2);
        chk("fault_nostep",  32'(step_cnt), 32'd10);
        chk("fault_errhold", 32'(err), 32'd1);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;
        chk("clear_err",   32'(err), 32'd0);
        chk("clear_code",  32'(err_code), 32'd0);
        chk("clear_state", 32'(dut.state_q), 32'(TRACK));
        gray_in = 3'b010; tick(4);
        chk("resume_bin",   32'(bin_out), 32'd3);
        chk("resume_steps", 32'(step_cnt), 32'd11);

        // Multi-bit jump
        enable = 1'b0; gray_in = 3'b000; tick(4);
        chk("rebase_bin", 32'(bin_out), 32'd0);
        enable = 1'b1; gray_in = 3'b011; tick(4);
        chk("jump_err",   32'(err), 32'd1);
        chk("jump_code",  32'(err_code), 32'd2);
        chk("jump_bin",   32'(bin_out), 32'd2);
        chk("jump_steps", 32'(step_cnt), 32'd11);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;

        // Disabled monitoring re-baselines silently
        enable = 1'b0; gray_in = 3'b000; tick(4);
        gray_in = 3'b110; tick(4);
        chk("dis_bin",   32'(bin_out), 32'd4);
        chk("dis_err",   32'(err), 32'd0);
        chk("dis_steps", 32'(step_cnt), 32'd11);
        enable = 1'b1; gray_in = 3'b111; tick(4);
        chk("reen_bin",   32'(bin_out), 32'd5);
        chk("reen_steps", 32'(step_cnt), 32'd12);

        // Back-to-back increments up to wrap_cnt saturation
        cur = 3'd5; exp_w = 1; exp_wp = 1; exp_steps = 12;
        while (exp_w < 255) begin
            cur = cur + 3'd1;
            gray_in = b2g(cur);
            if (cur == 3'd0) begin exp_w++; exp_wp++; end
            exp_steps++;
            tick(1);
        end
        tick(4);
        chk("sat_reach", 32'(wrap_cnt), 32'd255);
        chk("sat_bin",   32'(bin_out), 32'(cur));
        chk("sat_steps", 32'(step_cnt), 32'(exp_steps));
        chk("sat_err",   32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cur = cur + 3'd1;
            gray_in = b2g(cur);
            if (cur == 3'd0) exp_wp++;
            tick(1);
        end
        tick(4);
        chk("sat_hold",   32'(wrap_cnt), 32'd255);
        chk("sat_wraps",  32'(wrap_pulses), 32'(exp_wp));

        // Asynchronous reset mid-sequence, then refill
        gray_in = b2g(3'd1); tick(1);
        gray_in = b2g(3'd2);
        #3 reset = 1'b1;
        #1;
        chk("arst_bin",  32'(bin_out), 32'd0);
        chk("arst_wcnt", 32'(wrap_cnt), 32'd0);
        chk("arst_err",  32'(err), 32'd0);
        chk("arst_step", 32'(step), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("refill_state", 32'(dut.state_q), 32'(INIT));
        chk("refill_bin0",  32'(bin_out), 32'd0);
        tick(1);
        chk("refill_bin",   32'(bin_out), 32'd2);
        chk("refill_step",  32'(step), 32'd0);
        chk("refill_err",   32'(err), 32'd0);
        chk("refill_track", 32'(dut.state_q), 32'(TRACK));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
